// File: rtl/complex_dot_product_scheduler_pkg.sv
// Shared definitions for the complex dot-product scheduler: default sizes, FSM encoding, lane masking.
package complex_dot_product_scheduler_pkg;

  localparam int DEF_ELEM_W  = 64;
  localparam int DEF_NU      = 8;
  localparam int DEF_NREQ    = 4;
  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_LEN_W   = 16;
  localparam int DEF_PKG_GAP = 2;
  localparam int DEF_TIMEOUT = 1024;
  localparam int MAX_LANES   = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_FETCH,
    S_WAIT,
    S_RESP
  } state_t;

  // Bit i is set while lane i still carries a live element; rem = elements left from this package on.
  function automatic logic [MAX_LANES-1:0] lane_mask(input int rem);
    logic [MAX_LANES-1:0] m;
    for (int i = 0; i < MAX_LANES; i++) m[i] = (rem > i);
    return m;
  endfunction

endpackage

// File: rtl/complex_dot_product_scheduler_rr_arbiter.sv
// Round-robin pick of one requester at/after the pointer; the choice is captured on load and held.
module rr_arbiter_nreq #(
  parameter int NREQ  = 4,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] pick_idx;
  logic             found;

  always_comb begin
    int j;
    j        = 0;
    pick_idx = '0;
    found    = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      j = (int'(ptr) + off) % NREQ;
      if (!found && req[j]) begin
        found    = 1'b1;
        pick_idx = IDX_W'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant     <= '0;
      grant_idx <= '0;
    end else if (load) begin
      grant     <= {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
      grant_idx <= pick_idx;
    end
  end

endmodule

// File: rtl/complex_dot_product_scheduler.sv
// Time-shares one conjugate-complex dot-product engine among NREQ requesters.
// state   | meaning
// S_IDLE  | waiting for any request
// S_GRANT | winner held; operands latched, engine started (skipped to S_RESP for empty vectors)
// S_FETCH | one package read every PKG_GAP cycles, forwarded masked to the engine
// S_WAIT  | waiting for the engine result, bounded by TIMEOUT
// S_RESP  | one-cycle done pulse with result to the winner
module complex_dot_product_scheduler
  import complex_dot_product_scheduler_pkg::*;
#(
  parameter int ELEM_W  = DEF_ELEM_W,
  parameter int NU      = DEF_NU,
  parameter int NREQ    = DEF_NREQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int PKG_GAP = DEF_PKG_GAP,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*ADDR_W-1:0] req_base_a,
  input  logic [NREQ*ADDR_W-1:0] req_base_b,
  input  logic [NREQ*LEN_W-1:0]  req_len,
  output logic [NREQ-1:0]        done,
  output logic [ELEM_W-1:0]      result,
  output logic                   error,
  output logic [ADDR_W-1:0]      mem_a_addr,
  output logic [ADDR_W-1:0]      mem_b_addr,
  output logic                   mem_rd,
  input  logic [ELEM_W*NU-1:0]   mem_a_data,
  input  logic [ELEM_W*NU-1:0]   mem_b_data,
  output logic [31:0]            eng_total,
  output logic                   eng_start,
  output logic                   eng_read_now,
  output logic [ELEM_W*NU-1:0]   eng_first,
  output logic [ELEM_W*NU-1:0]   eng_second,
  input  logic                   eng_finish,
  input  logic [ELEM_W-1:0]      eng_result
);

  localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int LOG_NU = $clog2(NU);
  localparam int TMR_W  = $clog2(TIMEOUT + 1);
  localparam int GAP_W  = $clog2(PKG_GAP + 1);

  state_t            state, state_nxt;
  logic [NREQ-1:0]   grant;
  logic [IDX_W-1:0]  grant_idx, ptr;
  logic [ADDR_W-1:0] base_a_q, base_b_q;
  logic [LEN_W-1:0]  len_q, npkg_q, pkg_cnt, pkg_off;
  logic [GAP_W-1:0]  gap_cnt;
  logic [TMR_W-1:0]  tmr;
  logic [NU-1:0]     mask_q;
  logic              rd_q, last_q, start_q, err_q, load, issue, last_issue;
  logic [ELEM_W-1:0] res_q;
  logic [31:0]       total_q;
  logic [LEN_W-1:0]  sel_len;
  logic [LEN_W:0]    sel_npkg;

  rr_arbiter_nreq #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .req       (req),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign load       = (state == S_IDLE) && (|req);
  assign sel_len    = req_len[int'(grant_idx)*LEN_W +: LEN_W];
  assign sel_npkg   = ({1'b0, sel_len} + (LEN_W+1)'(NU - 1)) >> LOG_NU;
  assign issue      = (state == S_FETCH) && (gap_cnt == '0) && (pkg_cnt != npkg_q);
  assign last_issue = issue && ((pkg_cnt + LEN_W'(1)) == npkg_q);
  assign pkg_off    = pkg_cnt << LOG_NU;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    done         = '0;
    result       = '0;
    mem_rd       = issue;
    mem_a_addr   = '0;
    mem_b_addr   = '0;
    eng_first    = '0;
    eng_second   = '0;
    error        = err_q;
    eng_total    = total_q;
    eng_start    = start_q;
    eng_read_now = rd_q;
    case (state)
      S_IDLE:  if (|req) state_nxt = S_GRANT;
      S_GRANT: state_nxt = (sel_len == '0) ? S_RESP : S_FETCH;
      S_FETCH: if (rd_q && last_q) state_nxt = S_WAIT;
      S_WAIT:  if (eng_finish || (tmr == '0)) state_nxt = S_RESP;
      S_RESP: begin
        state_nxt = S_IDLE;
        done      = grant;
        result    = res_q;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (issue) begin
      mem_a_addr = base_a_q + ADDR_W'(pkg_cnt);
      mem_b_addr = base_b_q + ADDR_W'(pkg_cnt);
    end
    // Lane 0 sits in the MSBs; dead lanes of the final package are zeroed on both operands.
    if (rd_q) begin
      for (int i = 0; i < NU; i++) begin
        if (mask_q[i]) begin
          eng_first[(NU-1-i)*ELEM_W +: ELEM_W]  = mem_a_data[(NU-1-i)*ELEM_W +: ELEM_W];
          eng_second[(NU-1-i)*ELEM_W +: ELEM_W] = mem_b_data[(NU-1-i)*ELEM_W +: ELEM_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr      <= '0;
      base_a_q <= '0;
      base_b_q <= '0;
      len_q    <= '0;
      npkg_q   <= '0;
      pkg_cnt  <= '0;
      gap_cnt  <= '0;
      tmr      <= '0;
      mask_q   <= '0;
      rd_q     <= 1'b0;
      last_q   <= 1'b0;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
      res_q    <= '0;
      total_q  <= '0;
    end else begin
      start_q <= 1'b0;
      rd_q    <= issue;
      last_q  <= last_issue;
      if (issue) mask_q <= NU'(lane_mask(int'(len_q - pkg_off)));
      case (state)
        S_GRANT: begin
          base_a_q <= req_base_a[int'(grant_idx)*ADDR_W +: ADDR_W];
          base_b_q <= req_base_b[int'(grant_idx)*ADDR_W +: ADDR_W];
          len_q    <= sel_len;
          npkg_q   <= sel_npkg[LEN_W-1:0];
          pkg_cnt  <= '0;
          gap_cnt  <= '0;
          res_q    <= '0;
          if (sel_len != '0) begin
            start_q <= 1'b1;
            total_q <= 32'(sel_npkg) << LOG_NU;
          end
        end
        S_FETCH: begin
          if (issue) begin
            pkg_cnt <= pkg_cnt + LEN_W'(1);
            gap_cnt <= GAP_W'(PKG_GAP - 1);
          end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
          if (rd_q && last_q) tmr <= TMR_W'(TIMEOUT - 1);
        end
        S_WAIT: begin
          if (eng_finish) begin
            res_q <= eng_result;
          end else if (tmr == '0) begin
            err_q <= 1'b1;
            res_q <= '0;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        S_RESP: ptr <= (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + IDX_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_complex_dot_product_scheduler.sv
// Scoreboard bench: memory and engine models, expected results queued at request time and popped on done.
module tb_complex_dot_product_scheduler;

  localparam int ELEM_W = 64, NU = 8, NREQ = 4, ADDR_W = 16, LEN_W = 16;
  localparam int PKG_GAP = 2, TIMEOUT = 1024, ENG_LAT = 3;
  localparam int PW = ELEM_W * NU;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [ADDR_W-1:0] cfg_a [NREQ];
  logic [ADDR_W-1:0] cfg_b [NREQ];
  logic [LEN_W-1:0]  cfg_len [NREQ];
  logic [NREQ*ADDR_W-1:0] req_base_a, req_base_b;
  logic [NREQ*LEN_W-1:0]  req_len;
  logic [NREQ-1:0]   done;
  logic [ELEM_W-1:0] result;
  logic              error, mem_rd, eng_start, eng_read_now;
  logic [ADDR_W-1:0] mem_a_addr, mem_b_addr;
  logic [PW-1:0]     mem_a_data = '0, mem_b_data = '0, eng_first, eng_second;
  logic [31:0]       eng_total;
  logic              eng_finish = 1'b0;
  logic [ELEM_W-1:0] eng_result = '0;

  complex_dot_product_scheduler dut (
    .clk(clk), .reset(reset), .req(req),
    .req_base_a(req_base_a), .req_base_b(req_base_b), .req_len(req_len),
    .done(done), .result(result), .error(error),
    .mem_a_addr(mem_a_addr), .mem_b_addr(mem_b_addr), .mem_rd(mem_rd),
    .mem_a_data(mem_a_data), .mem_b_data(mem_b_data),
    .eng_total(eng_total), .eng_start(eng_start), .eng_read_now(eng_read_now),
    .eng_first(eng_first), .eng_second(eng_second),
    .eng_finish(eng_finish), .eng_result(eng_result)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_base_a = '0;
    req_base_b = '0;
    req_len    = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_base_a[i*ADDR_W +: ADDR_W] = cfg_a[i];
      req_base_b[i*ADDR_W +: ADDR_W] = cfg_b[i];
      req_len[i*LEN_W +: LEN_W]      = cfg_len[i];
    end
  end

  logic [PW-1:0] ma [0:65535];
  logic [PW-1:0] mb [0:65535];

  always @(posedge clk) begin
    if (mem_rd) begin
      mem_a_data <= ma[mem_a_addr];
      mem_b_data <= mb[mem_b_addr];
    end
  end

  function automatic logic [ELEM_W-1:0] cmac(input logic [ELEM_W-1:0] acc,
                                             input logic [ELEM_W-1:0] a, input logic [ELEM_W-1:0] b);
    logic signed [31:0] ar, ai, br, bi, rr, ri;
    ar = a[63:32]; ai = a[31:0]; br = b[63:32]; bi = b[31:0];
    rr = $signed(acc[63:32]) + ar * br + ai * bi;
    ri = $signed(acc[31:0]) + ai * br - ar * bi;
    return {rr, ri};
  endfunction

  function automatic logic [ELEM_W-1:0] lane_of(input logic [PW-1:0] p, input int i);
    return p[(NU-1-i)*ELEM_W +: ELEM_W];
  endfunction

  function automatic logic [ELEM_W-1:0] golden(input int ba, input int bb, input int len);
    logic [ELEM_W-1:0] acc;
    acc = '0;
    for (int e = 0; e < len; e++)
      acc = cmac(acc, lane_of(ma[16'(ba + e / NU)], e % NU), lane_of(mb[16'(bb + e / NU)], e % NU));
    return acc;
  endfunction

  // External engine: accumulates a*conj(b) over every presented lane, answers ENG_LAT cycles later.
  logic [ELEM_W-1:0] acc;
  int lanes_got, fin_cd;
  bit eng_hang = 1'b0;
  always @(posedge clk) begin
    eng_finish <= 1'b0;
    if (reset) begin
      acc = '0; lanes_got = 0; fin_cd = 0;
    end else begin
      if (eng_start) begin
        acc = '0; lanes_got = 0; fin_cd = 0;
      end
      if (eng_read_now) begin
        for (int i = 0; i < NU; i++) acc = cmac(acc, lane_of(eng_first, i), lane_of(eng_second, i));
        lanes_got += NU;
        if (lanes_got == int'(eng_total) && !eng_hang) fin_cd = ENG_LAT;
      end else if (fin_cd > 0) begin
        fin_cd--;
        if (fin_cd == 0) begin
          eng_finish <= 1'b1;
          eng_result <= acc;
        end
      end
    end
  end

  typedef struct { int idx; logic [ELEM_W-1:0] res; } exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_mis = 0, cyc = 0, n_start = 0, exp_ptr = 0;
  logic [31:0] tot_seen;
  int rd_cyc[$];
  logic [PW-1:0] pk_a[$], pk_b[$];

  task automatic clear_mon();
    n_start = 0; tot_seen = '0;
    rd_cyc.delete(); pk_a.delete(); pk_b.delete();
  endtask

  task automatic wait_done(input int budget, output bit got, output logic [NREQ-1:0] d,
                           output logic [ELEM_W-1:0] r);
    got = 1'b0; d = '0; r = '0;
    for (int c = 0; c < budget && !got; c++) begin
      @(negedge clk);
      cyc++;
      if (eng_start) begin n_start++; tot_seen = eng_total; end
      if (eng_read_now) begin rd_cyc.push_back(cyc); pk_a.push_back(eng_first); pk_b.push_back(eng_second); end
      if (|done) begin got = 1'b1; d = done; r = result; end
    end
  endtask

  task automatic fill_ones(input int ba, input int bb, input int npk);
    for (int p = 0; p < npk; p++)
      for (int i = 0; i < NU; i++) begin
        ma[16'(ba + p)][(NU-1-i)*ELEM_W +: ELEM_W] = {32'd1, 32'd1};
        mb[16'(bb + p)][(NU-1-i)*ELEM_W +: ELEM_W] = {32'd1, 32'd1};
      end
  endtask

  task automatic fill_rand(input int ba, input int bb, input int npk);
    for (int p = 0; p < npk; p++)
      for (int i = 0; i < NU; i++) begin
        ma[16'(ba + p)][(NU-1-i)*ELEM_W +: ELEM_W] = {32'($urandom_range(1, 9)), 32'($urandom_range(1, 9))};
        mb[16'(bb + p)][(NU-1-i)*ELEM_W +: ELEM_W] = {32'($urandom_range(1, 9)), 32'($urandom_range(1, 9))};
      end
  endtask

  task automatic set_cfg(input int i, input int a, input int b, input int len);
    cfg_a[i] = ADDR_W'(a); cfg_b[i] = ADDR_W'(b); cfg_len[i] = LEN_W'(len);
  endtask

  // Pops the scoreboard on a done and checks which requester and what result.
  task automatic check_done(input string name, input bit got, input logic [NREQ-1:0] d,
                            input logic [ELEM_W-1:0] r);
    exp_t e;
    logic [NREQ-1:0] exp_d;
    n_cmp++;
    if (!got) begin
      $display("FAIL %s_arrival: got no done, expected done within budget", name);
      n_mis++;
      sb.delete();
    end else begin
      e = sb.pop_front();
      exp_d = '0; exp_d[e.idx] = 1'b1;
      exp_ptr = (e.idx + 1) % NREQ;
      n_cmp++;
      if (d !== exp_d) begin $display("FAIL %s_done: got %b expected %b", name, d, exp_d); n_mis++; end
      n_cmp++;
      if (r !== e.res) begin $display("FAIL %s_result: got %h expected %h", name, r, e.res); n_mis++; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({done, result, error, mem_rd, mem_a_addr, mem_b_addr, eng_start, eng_read_now, eng_total} !== '0) begin
      $display("FAIL reset_ctrl: got done=%b result=%h error=%b mem_rd=%b eng_start=%b expected all 0",
               done, result, error, mem_rd, eng_start); n_mis++;
    end
    n_cmp++;
    if ({eng_first, eng_second} !== '0) begin
      $display("FAIL reset_data: got nonzero engine operands expected 0"); n_mis++;
    end
    reset = 1'b0;
  endtask

  task automatic test_len16();
    bit got; logic [NREQ-1:0] d; logic [ELEM_W-1:0] r;
    fill_ones(0, 0, 2);
    set_cfg(0, 0, 0, 16);
    clear_mon();
    sb.push_back('{0, {32'd32, 32'd0}});
    req = 4'b0001;
    wait_done(200, got, d, r);
    req = '0;
    check_done("len16", got, d, r);
    n_cmp++;
    if (n_start != 1) begin $display("FAIL len16_starts: got %0d expected 1", n_start); n_mis++; end
    n_cmp++;
    if (tot_seen !== 32'd16) begin $display("FAIL len16_total: got %0d expected 16", tot_seen); n_mis++; end
    n_cmp++;
    if (rd_cyc.size() != 2) begin
      $display("FAIL len16_pkgs: got %0d expected 2", rd_cyc.size()); n_mis++;
    end else begin
      n_cmp++;
      if (rd_cyc[1] - rd_cyc[0] != PKG_GAP) begin
        $display("FAIL len16_gap: got %0d expected %0d", rd_cyc[1] - rd_cyc[0], PKG_GAP); n_mis++;
      end
    end
  endtask

  task automatic test_len10();
    bit got; logic [NREQ-1:0] d; logic [ELEM_W-1:0] r;
    fill_rand(8, 20, 2);
    set_cfg(1, 8, 20, 10);
    clear_mon();
    sb.push_back('{1, golden(8, 20, 10)});
    req = 4'b0010;
    wait_done(200, got, d, r);
    req = '0;
    check_done("len10", got, d, r);
    n_cmp++;
    if (pk_a.size() != 2) begin
      $display("FAIL len10_pkgs: got %0d expected 2", pk_a.size()); n_mis++;
    end else begin
      n_cmp++;
      if ({pk_a[1][6*ELEM_W-1:0], pk_b[1][6*ELEM_W-1:0]} !== '0) begin
        $display("FAIL len10_mask: got nonzero lanes 2..7 expected 0"); n_mis++;
      end
      n_cmp++;
      if (pk_a[1][PW-1 -: 2*ELEM_W] !== ma[9][PW-1 -: 2*ELEM_W]) begin
        $display("FAIL len10_live: got %h expected %h", pk_a[1][PW-1 -: 2*ELEM_W], ma[9][PW-1 -: 2*ELEM_W]);
        n_mis++;
      end
    end
  endtask

  task automatic test_len0();
    bit got; logic [NREQ-1:0] d; logic [ELEM_W-1:0] r;
    set_cfg(2, 5, 5, 0);
    clear_mon();
    sb.push_back('{2, 64'd0});
    req = 4'b0100;
    wait_done(3, got, d, r);
    req = '0;
    check_done("len0", got, d, r);
    n_cmp++;
    if (n_start != 0) begin $display("FAIL len0_start: got %0d starts expected 0", n_start); n_mis++; end
  endtask

  task automatic test_round_robin();
    bit got; logic [NREQ-1:0] d; logic [ELEM_W-1:0] r;
    int lens[NREQ] = '{3, 9, 17, 8};
    fill_rand(120, 140, 20);
    for (int i = 0; i < NREQ; i++) set_cfg(i, 120 + 4 * i, 140 + 4 * i, lens[i]);
    for (int k = 0; k < NREQ + 1; k++) begin
      int w;
      w = (exp_ptr + k) % NREQ;
      sb.push_back('{w, golden(120 + 4 * w, 140 + 4 * w, lens[w])});
    end
    clear_mon();
    req = 4'b1111;
    for (int k = 0; k < NREQ + 1; k++) begin
      wait_done(300, got, d, r);
      if (k == NREQ) req = '0;
      check_done("rr", got, d, r);
    end
    req = '0;
  endtask

  task automatic test_timeout();
    bit got; logic [NREQ-1:0] d; logic [ELEM_W-1:0] r;
    fill_rand(200, 210, 1);
    set_cfg(3, 200, 210, 8);
    eng_hang = 1'b1;
    sb.push_back('{3, 64'd0});
    req = 4'b1000;
    wait_done(TIMEOUT + 100, got, d, r);
    req = '0;
    eng_hang = 1'b0;
    check_done("timeout", got, d, r);
    n_cmp++;
    if (error !== 1'b1) begin $display("FAIL timeout_error: got %b expected 1", error); n_mis++; end
    fill_rand(100, 110, 2);
    set_cfg(0, 100, 110, 12);
    sb.push_back('{0, golden(100, 110, 12)});
    req = 4'b0001;
    wait_done(200, got, d, r);
    req = '0;
    check_done("after_timeout", got, d, r);
    n_cmp++;
    if (error !== 1'b1) begin $display("FAIL error_sticky: got %b expected 1", error); n_mis++; end
  endtask

  task automatic test_reset_mid_fetch();
    bit got, seen; logic [NREQ-1:0] d; logic [ELEM_W-1:0] r;
    fill_rand(40, 60, 8);
    set_cfg(1, 40, 60, 64);
    req = 4'b0010;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      seen = eng_read_now;
    end
    n_cmp++;
    if (!seen) begin $display("FAIL midreset_fetch: got no package expected one within 50 cycles"); n_mis++; end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({done, result, error, mem_rd, eng_start, eng_read_now, eng_total, mem_a_addr} !== '0) begin
      $display("FAIL midreset_out: got done=%b error=%b mem_rd=%b read_now=%b total=%0d expected all 0",
               done, error, mem_rd, eng_read_now, eng_total); n_mis++;
    end
    n_cmp++;
    if (eng_first !== '0) begin $display("FAIL midreset_first: got nonzero expected 0"); n_mis++; end
    reset = 1'b0;
    exp_ptr = 0;
    sb.delete();
    sb.push_back('{1, golden(40, 60, 64)});
    clear_mon();
    wait_done(300, got, d, r);
    req = '0;
    check_done("after_reset", got, d, r);
    n_cmp++;
    if (error !== 1'b0) begin $display("FAIL midreset_error: got %b expected 0", error); n_mis++; end
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) set_cfg(i, 0, 0, 0);
    test_reset();
    test_len16();
    test_len10();
    test_len0();
    test_round_robin();
    test_timeout();
    test_reset_mid_fetch();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
